// File: rtl/cpu_mem_pkg.sv
// Shared constants for the CPU-side memory path: response owner encoding,
// byte-enable width and the default fetch starvation guard.
package cpu_mem_pkg;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_INST = 2'd1;
   localparam logic [1:0] OWN_DATA = 2'd2;

   localparam int unsigned DEF_MAX_DATA_STREAK = 4;
   localparam int unsigned BE_W                = 4;

endpackage

// File: rtl/sram_port_arbiter.sv
// Arbitrates fetch and memory-stage accesses onto one single-port SRAM and
// routes the 1-cycle-latency read data back to whichever side issued it.
module sram_port_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
   parameter int unsigned ADDR_W          = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_cancel,
   output logic              inst_gnt,
   output logic              inst_rvalid,
   output logic [31:0]       inst_rdata,
   input  logic              data_req,
   input  logic [BE_W-1:0]   data_wen,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [31:0]       data_wdata,
   output logic              data_gnt,
   output logic              data_rvalid,
   output logic [31:0]       data_rdata,
   output logic              sram_en,
   output logic [BE_W-1:0]   sram_wen,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [31:0]       sram_wdata,
   input  logic [31:0]       sram_rdata
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

   logic [3:0] streak_q;
   logic [1:0] resp_owner_q;
   logic       inst_cancel_d;
   logic       grant_inst;
   logic       grant_data;

   // Data wins unless fetch has already waited out a full streak; a cancelled
   // fetch never blocks data.
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (resetn) begin
         if (data_req && (!inst_req || (streak_q < STREAK_MAX))) begin
            grant_data = 1'b1;
         end else if (inst_req && !inst_cancel) begin
            grant_inst = 1'b1;
         end else if (data_req) begin
            grant_data = 1'b1;
         end
      end
   end

   always_comb begin
      sram_en    = 1'b0;
      sram_wen   = '0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (grant_data) begin
         sram_en    = 1'b1;
         sram_wen   = data_wen;
         sram_addr  = data_addr;
         sram_wdata = data_wdata;
      end else if (grant_inst) begin
         sram_en   = 1'b1;
         sram_addr = inst_addr;
      end
   end

   assign inst_gnt = grant_inst;
   assign data_gnt = grant_data;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         streak_q      <= 4'd0;
         resp_owner_q  <= OWN_NONE;
         inst_cancel_d <= 1'b0;
      end else begin
         // The streak only measures how long a waiting fetch has been passed over.
         if (!inst_req || grant_inst) begin
            streak_q <= 4'd0;
         end else if (grant_data && (streak_q < STREAK_MAX)) begin
            streak_q <= streak_q + 4'd1;
         end

         if (grant_inst) begin
            resp_owner_q <= OWN_INST;
         end else if (grant_data && (data_wen == '0)) begin
            resp_owner_q <= OWN_DATA;
         end else begin
            resp_owner_q <= OWN_NONE;
         end

         inst_cancel_d <= inst_cancel;
      end
   end

   // A cancel seen in either the grant or the response cycle kills the fetch
   // response; reset also drops any response still in flight.
   assign inst_rvalid = resetn && (resp_owner_q == OWN_INST) && !inst_cancel_d && !inst_cancel;
   assign data_rvalid = resetn && (resp_owner_q == OWN_DATA);

   assign inst_rdata = inst_rvalid ? sram_rdata : 32'd0;
   assign data_rdata = data_rvalid ? sram_rdata : 32'd0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: per-cycle grant/bus expectations and
// read responses go into queues that a negedge monitor drains and compares.
module tb_sram_port_arbiter;
   import cpu_mem_pkg::*;

   localparam logic [1:0] G_N = 2'b00;
   localparam logic [1:0] G_D = 2'b01;
   localparam logic [1:0] G_I = 2'b10;

   typedef struct packed {
      logic [1:0]  g;
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_exp_t;

   typedef struct packed {
      int          cyc;
      logic [31:0] val;
   } resp_exp_t;

   // clock / reset / DUT
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_req = 1'b0;
   logic [31:0] inst_addr = '0;
   logic        inst_cancel = 1'b0;
   logic        inst_gnt, inst_rvalid;
   logic [31:0] inst_rdata;
   logic        data_req = 1'b0;
   logic [3:0]  data_wen = '0;
   logic [31:0] data_addr = '0;
   logic [31:0] data_wdata = '0;
   logic        data_gnt, data_rvalid;
   logic [31:0] data_rdata;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr, sram_wdata;
   logic [31:0] sram_rdata = '0;

   int cyc_n = 0;
   int total = 0;
   int bad = 0;

   bus_exp_t  g_q[$];
   resp_exp_t i_q[$];
   resp_exp_t d_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   sram_port_arbiter #(.MAX_DATA_STREAK(4), .ADDR_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
      .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
      .data_rdata(data_rdata),
      .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   // SRAM model: word index from addr[9:2]; idle cycles return junk so that
   // rdata gating is visible.
   logic [31:0] mem [0:255];

   function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (sram_en && sram_wen == 4'h0) begin
         sram_rdata <= mem[sram_addr[9:2]];
      end else begin
         sram_rdata <= 32'hFFFF_FFFF;
         if (sram_en) mem[sram_addr[9:2]] <= merge(mem[sram_addr[9:2]], sram_wdata, sram_wen);
      end
   end

   // Requester fields must hold while waiting for a grant (cancel releases fetch).
   logic        p_rst = 1'b0, p_ireq = 1'b0, p_ignt = 1'b0, p_icancel = 1'b0;
   logic        p_dreq = 1'b0, p_dgnt = 1'b0;
   logic [31:0] p_iaddr = '0, p_daddr = '0, p_dwdata = '0;
   logic [3:0]  p_dwen = '0;

   always @(posedge clk) begin
      if (p_rst && resetn && p_ireq && !p_ignt && !p_icancel)
         assert (inst_req && inst_addr == p_iaddr) else $error("protocol: fetch request changed while waiting");
      if (p_rst && resetn && p_dreq && !p_dgnt)
         assert (data_req && data_addr == p_daddr && data_wen == p_dwen && data_wdata == p_dwdata)
            else $error("protocol: data request changed while waiting");
      p_rst <= resetn;     p_ireq <= inst_req;   p_ignt <= inst_gnt;   p_icancel <= inst_cancel;
      p_iaddr <= inst_addr; p_dreq <= data_req;  p_dgnt <= data_gnt;   p_daddr <= data_addr;
      p_dwen <= data_wen;  p_dwdata <= data_wdata;
   end

   // scoreboard helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc_n, act, exp);
      end
   endtask

   // driver: one cycle of stimulus plus its expected grant and response
   task automatic step(input logic r, input logic ir, input logic [31:0] ia, input logic ic,
                       input logic dr, input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dd, input logic [1:0] eg, input logic er,
                       input logic [31:0] ev);
      bus_exp_t b;
      @(posedge clk);
      #1;
      resetn = r;  inst_req = ir; inst_addr = ia; inst_cancel = ic;
      data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
      b = '{g: eg, wen: 4'h0, addr: 32'h0, wdata: 32'h0};
      if (eg == G_D) begin
         b.wen = dw; b.addr = da; b.wdata = dd;
      end else if (eg == G_I) begin
         b.addr = ia;
      end
      g_q.push_back(b);
      if (er && eg == G_I) i_q.push_back('{cyc: cyc_n + 1, val: ev});
      if (er && eg == G_D) d_q.push_back('{cyc: cyc_n + 1, val: ev});
   endtask

   task automatic idle();
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, G_N, 1'b0, 32'h0);
   endtask

   // monitor
   initial begin
      bus_exp_t  b;
      resp_exp_t e;
      logic      exp_v;
      forever begin
         @(negedge clk);
         if (g_q.size() > 0) begin
            b = g_q.pop_front();
            chk("gnt", 32'({inst_gnt, data_gnt}), 32'(b.g));
            chk("sram_en", 32'(sram_en), 32'(|b.g));
            chk("sram_wen", 32'(sram_wen), 32'(b.wen));
            chk("sram_addr", sram_addr, b.addr);
            chk("sram_wdata", sram_wdata, b.wdata);

            exp_v = (i_q.size() > 0) && (i_q[0].cyc == cyc_n);
            chk("inst_rvalid", 32'(inst_rvalid), 32'(exp_v));
            if (exp_v) begin
               e = i_q.pop_front();
               chk("inst_rdata", inst_rdata, e.val);
            end else begin
               chk("inst_rdata_idle", inst_rdata, 32'h0);
            end

            exp_v = (d_q.size() > 0) && (d_q[0].cyc == cyc_n);
            chk("data_rvalid", 32'(data_rvalid), 32'(exp_v));
            if (exp_v) begin
               e = d_q.pop_front();
               chk("data_rdata", data_rdata, e.val);
            end else begin
               chk("data_rdata_idle", data_rdata, 32'h0);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h00] = 32'h2401_0001;   // 0xBFC00000
      mem[8'h01] = 32'h3C1D_A000;   // 0xBFC00004
      mem[8'h02] = 32'h27BD_FFF0;   // 0xBFC00008
      mem[8'h40] = 32'h1122_3344;   // 0x100
      mem[8'h80] = 32'hDEAD_BEEF;   // 0x200
      mem[8'h81] = 32'h0BAD_F00D;   // 0x204

      // reset: no grants even with both requesting
      step(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 4'h0, 32'h0,   32'h0, G_N, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 1'b1, 4'h0, 32'h200, 32'h0, G_N, 1'b0, 32'h0);

      // single fetch
      step(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, G_I, 1'b1, 32'h2401_0001);
      idle();

      // partial write then read back, write gives no response
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'b0011, 32'h100, 32'hAABB_CCDD, G_D, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0,    32'h100, 32'h0,        G_D, 1'b1, 32'h1122_CCDD);
      idle();

      // cancel in the response cycle; cancelled fetch leaves the slot to data
      step(1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, G_I, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 4'h0, 32'h0,   32'h0, G_N, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'hBFC0_0008, 1'b1, 1'b1, 4'h0, 32'h200, 32'h0, G_D, 1'b1, 32'hDEAD_BEEF);
      idle();

      // alternating fetch/data reads, responses overlap next grants
      step(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, G_I, 1'b1, 32'h2401_0001);
      step(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 4'h0, 32'h204, 32'h0, G_D, 1'b1, 32'h0BAD_F00D);
      step(1'b1, 1'b1, 32'hBFC0_0004, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, G_I, 1'b1, 32'h3C1D_A000);
      step(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 4'h0, 32'h200, 32'h0, G_D, 1'b1, 32'hDEAD_BEEF);
      step(1'b1, 1'b1, 32'hBFC0_0008, 1'b0, 1'b0, 4'h0, 32'h0,   32'h0, G_I, 1'b1, 32'h27BD_FFF0);
      step(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 4'h0, 32'h100, 32'h0, G_D, 1'b1, 32'h1122_CCDD);
      idle();

      // continuous contention: D,D,D,D,I,D,D,D,D,I then the waiting data read
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++)
            step(1'b1, 1'b1, (k == 0) ? 32'hBFC0_0004 : 32'hBFC0_0008, 1'b0, 1'b1, 4'h0,
                 (j % 2 == 0) ? 32'h200 : 32'h204, 32'h0, G_D, 1'b1,
                 (j % 2 == 0) ? 32'hDEAD_BEEF : 32'h0BAD_F00D);
         step(1'b1, 1'b1, (k == 0) ? 32'hBFC0_0004 : 32'hBFC0_0008, 1'b0, 1'b1, 4'h0, 32'h200,
              32'h0, G_I, 1'b1, (k == 0) ? 32'h3C1D_A000 : 32'h27BD_FFF0);
      end
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h200, 32'h0, G_D, 1'b1, 32'hDEAD_BEEF);
      idle();

      // reset right after a data read grant: response dropped, streak restarts
      step(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 1'b1, 4'h0, 32'h200, 32'h0, G_D, 1'b1, 32'hDEAD_BEEF);
      step(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 1'b1, 4'h0, 32'h204, 32'h0, G_D, 1'b1, 32'h0BAD_F00D);
      step(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 1'b1, 4'h0, 32'h200, 32'h0, G_D, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'hBFC0_0000, 1'b0, 1'b1, 4'h0, 32'h204, 32'h0, G_N, 1'b0, 32'h0);
      for (int j = 0; j < 4; j++)
         step(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 1'b1, 4'h0, (j % 2 == 0) ? 32'h204 : 32'h200,
              32'h0, G_D, 1'b1, (j % 2 == 0) ? 32'h0BAD_F00D : 32'hDEAD_BEEF);
      step(1'b1, 1'b1, 32'hBFC0_0000, 1'b0, 1'b1, 4'h0, 32'h204, 32'h0, G_I, 1'b1, 32'h2401_0001);
      step(1'b1, 1'b0, 32'h0,         1'b0, 1'b1, 4'h0, 32'h204, 32'h0, G_D, 1'b1, 32'h0BAD_F00D);
      idle();
      idle();

      @(negedge clk);
      #1;
      chk("grant_queue_drained", 32'(g_q.size()), 32'h0);
      chk("inst_resp_drained", 32'(i_q.size()), 32'h0);
      chk("data_resp_drained", 32'(d_q.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port unified SRAM between the fetch stage (instruction reads) and the memory stage (data reads/writes).
- Sits between the CPU core and the SoC memory.
- Grants at most one access per cycle. Data has priority, with a starvation guard for fetch.
- Routes the 1-cycle-latency read data back to the requester that issued it.

Parameters:
- MAX_DATA_STREAK, 4, consecutive data grants allowed while inst_req is waiting before one inst grant is forced (range 1..15).
- ADDR_W, 32, address width of all address ports.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- inst_req  in  1  fetch requests a read; held with inst_addr until inst_gnt
- inst_addr  in  ADDR_W  fetch byte address
- inst_cancel  in  1  pipeline cancel; kills the in-flight/new fetch
- inst_gnt  out  1  fetch request accepted this cycle
- inst_rvalid  out  1  inst_rdata valid
- inst_rdata  out  32  fetched word
- data_req  in  1  memory-stage request; held with its fields until data_gnt
- data_wen  in  4  byte write enables; 0 = read
- data_addr  in  ADDR_W  data byte address
- data_wdata  in  32  store data
- data_gnt  out  1  data request accepted this cycle
- data_rvalid  out  1  data_rdata valid (reads only)
- data_rdata  out  32  loaded word
- sram_en  out  1  SRAM enable
- sram_wen  out  4  SRAM byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after the enable

Behaviour:
- Grant decision is combinational in cycle N.
- Priority, in order:
  - resetn=0 → no grant.
  - data_req & (~inst_req | streak<MAX_DATA_STREAK) → data.
  - inst_req & ~inst_cancel → inst.
  - data_req (inst blocked by cancel) → data.
  - else idle.
- SRAM bus mux:
  - sram_en=1 only when a grant is given.
  - sram_addr, sram_wen and sram_wdata come from the granted requester.
  - Inst grant: sram_wen=0, sram_wdata=0.
  - Idle: sram_en=0, all other SRAM outputs 0.
- streak register (4 bits, reset 0):
  - +1 when data is granted while inst_req=1, saturating at MAX_DATA_STREAK.
  - Cleared on an inst grant or whenever inst_req=0.
- resp_owner register (NONE/INST/DATA, reset NONE):
  - Set in cycle N to INST for an inst grant, to DATA for a data read grant (data_wen==0), else NONE.
- Response in cycle N+1:
  - inst_rvalid = (resp_owner==INST) & ~inst_cancel_d. inst_cancel_d is inst_cancel registered in cycle N, reset 0.
  - data_rvalid = (resp_owner==DATA).
  - Both rdata outputs = sram_rdata when their rvalid is set, else 0.
- Cancel: inst_cancel in the grant cycle or in the response cycle suppresses inst_rvalid; the SRAM read still occurs. Data traffic is unaffected.
- Writes complete on data_gnt and produce no data_rvalid.
- Back-to-back: a new grant is allowed every cycle, and responses pipeline. A response from N and a grant in N+1 may coexist.
- Simultaneous requests with streak==MAX_DATA_STREAK: inst is granted, data waits exactly one cycle.
- Reset mid-operation: all registers go to reset values. A pending response is dropped (rvalid=0 the next cycle). All gnt and sram_en outputs are 0 while resetn=0.
- Reset values: inst_gnt, data_gnt, inst_rvalid, data_rvalid, sram_en = 0; rdata, sram_* = 0.
- Protocol: requester fields must stay stable while req=1 and gnt=0. A violation is undefined; the bench asserts on it.

Decomposition:
- Shared package cpu_mem_pkg holds:
  - owner encoding constants OWN_NONE=2'd0, OWN_INST=2'd1, OWN_DATA=2'd2;
  - default MAX_DATA_STREAK;
  - byte-enable width constant (4).
- No sub-module. Grant logic, the streak counter and the response register fit in a single module.

Test Plan:
- inst_req only, addr 0xBFC00000, SRAM returns 0x24010001 → inst_gnt in N, inst_rvalid=1 with 0x24010001 in N+1; data_rvalid=0.
- Both requesting continuously, MAX_DATA_STREAK=4 → grant pattern D,D,D,D,I,D,D,D,D,I; no cycle without a grant.
- Data write wen=4'b0011, addr 0x100, wdata 0xAABBCCDD → sram_wen=0011 for one cycle, data_gnt=1, no data_rvalid next cycle; a subsequent read of 0x100 returns data_rvalid.
- inst granted in N, inst_cancel=1 in N+1 → inst_rvalid stays 0. inst_req+inst_cancel together with data_req → data granted.
- Alternating inst/data reads every cycle → each rvalid appears exactly one cycle after its gnt, with the correct rdata routed and no cross-delivery.
- resetn=0 in the cycle after a data read grant → data_rvalid=0, streak=0; after release, the first request is granted normally.
